// File: rtl/tone_synth_if.sv
`default_nettype none
// ============================================================================
// tone_synth_if : note word / mute in, speaker and envelope status out  (rev 1.0)
// ============================================================================
interface tone_synth_if #(
  parameter int CNT_W = 26,
  parameter int ENV_W = 8
);
  logic [CNT_W-1:0] half_period;
  logic             mute;
  logic             audio;
  logic             note_active;
  logic [ENV_W-1:0] level;

  modport master (
    output half_period,
    output mute,
    input  audio,
    input  note_active,
    input  level
  );

  modport slave (
    input  half_period,
    input  mute,
    output audio,
    output note_active,
    output level
  );
endinterface
`default_nettype wire

// File: rtl/tone_synth.sv
`default_nettype none
// ============================================================================
// tone_synth : glitch-filtered square-wave tone with linear attack/release PWM envelope  (rev 1.0)
// ============================================================================
module tone_synth #(
  parameter int CNT_W        = 26,
  parameter int STABLE_CYC   = 1000,
  parameter int MIN_HALF     = 16,
  parameter int ENV_W        = 8,
  parameter int ENV_STEP_CYC = 50000
) (
  input wire          CLK,
  input wire          RST_N,
  tone_synth_if.slave tone_io
);
  localparam int STAB_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam int ENVC_W = (ENV_STEP_CYC > 1) ? $clog2(ENV_STEP_CYC) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYC - 1);
  localparam logic [ENVC_W-1:0] ENV_LAST  = ENVC_W'(ENV_STEP_CYC - 1);
  localparam logic [CNT_W-1:0]  MIN_H     = CNT_W'(MIN_HALF);
  localparam logic [ENV_W-1:0]  LVL_MAX   = '1;
  localparam logic [ENV_W-1:0]  LVL_ONE   = ENV_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ATTACK  = 2'd1,
    S_SUSTAIN = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cand_q, cand_d, acc_q, acc_d;
  logic [CNT_W-1:0]  cur_half_q, cur_half_d, pend_q, pend_d, tone_cnt_q, tone_cnt_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [ENVC_W-1:0] env_cnt_q, env_cnt_d;
  logic [ENV_W-1:0]  level_q, level_d, pwm_q, pwm_d;
  logic              sq_q, sq_d, audio_q, audio_d;
  logic [CNT_W-1:0]  eff;
  logic              new_note, to_idle;

  // The accepted word is forwarded in the same cycle it is latched into acc.
  always_comb begin
    cand_d   = cand_q;
    stab_d   = stab_q;
    acc_d    = acc_q;
    new_note = 1'b0;
    eff      = (tone_io.mute || (tone_io.half_period < MIN_H)) ? '0 : tone_io.half_period;
    if (eff != cand_q) begin
      cand_d = eff;
      stab_d = '0;
    end else if (stab_q < STAB_LAST) begin
      stab_d = stab_q + 1'b1;
    end else if (cand_q != acc_q) begin
      acc_d    = cand_q;
      new_note = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_half_d = cur_half_q;
    pend_d     = pend_q;
    tone_cnt_d = tone_cnt_q;
    sq_d       = sq_q;
    env_cnt_d  = env_cnt_q;
    level_d    = level_q;
    to_idle    = 1'b0;
    pwm_d      = pwm_q + 1'b1;
    audio_d    = sq_q && (pwm_q < level_q);

    if (state_q != S_IDLE) begin
      if (tone_cnt_q == cur_half_q - 1'b1) begin
        sq_d       = ~sq_q;
        tone_cnt_d = '0;
        if (pend_q != '0) begin
          cur_half_d = pend_q;
          pend_d     = '0;
        end
      end else begin
        tone_cnt_d = tone_cnt_q + 1'b1;
      end
    end

    // A pitch request recorded here overrides one just consumed at a toggle.
    if (new_note && (acc_d != '0)) begin
      pend_d = acc_d;
      if (state_q == S_IDLE) begin
        state_d    = S_ATTACK;
        cur_half_d = acc_d;
        pend_d     = '0;
        tone_cnt_d = '0;
        sq_d       = 1'b0;
        env_cnt_d  = '0;
      end else if (state_q == S_RELEASE) begin
        state_d   = S_ATTACK;
        env_cnt_d = '0;
      end
    end else if (new_note) begin
      if ((state_q == S_ATTACK) || (state_q == S_SUSTAIN)) begin
        state_d   = S_RELEASE;
        env_cnt_d = '0;
      end
    end else begin
      case (state_q)
        S_ATTACK: begin
          if (level_q == LVL_MAX) begin
            state_d   = S_SUSTAIN;
            env_cnt_d = '0;
          end else if (env_cnt_q == ENV_LAST) begin
            env_cnt_d = '0;
            level_d   = level_q + 1'b1;
            if (level_q == LVL_MAX - LVL_ONE) state_d = S_SUSTAIN;
          end else begin
            env_cnt_d = env_cnt_q + 1'b1;
          end
        end
        S_RELEASE: begin
          if (level_q == '0) begin
            to_idle = 1'b1;
          end else if (env_cnt_q == ENV_LAST) begin
            env_cnt_d = '0;
            level_d   = level_q - 1'b1;
            if (level_q == LVL_ONE) to_idle = 1'b1;
          end else begin
            env_cnt_d = env_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (to_idle) begin
      state_d    = S_IDLE;
      sq_d       = 1'b0;
      tone_cnt_d = '0;
      pend_d     = '0;
      env_cnt_d  = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      cand_q     <= '0;
      stab_q     <= '0;
      acc_q      <= '0;
      cur_half_q <= '0;
      pend_q     <= '0;
      tone_cnt_q <= '0;
      sq_q       <= 1'b0;
      env_cnt_q  <= '0;
      level_q    <= '0;
      pwm_q      <= '0;
      audio_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      stab_q     <= stab_d;
      acc_q      <= acc_d;
      cur_half_q <= cur_half_d;
      pend_q     <= pend_d;
      tone_cnt_q <= tone_cnt_d;
      sq_q       <= sq_d;
      env_cnt_q  <= env_cnt_d;
      level_q    <= level_d;
      pwm_q      <= pwm_d;
      audio_q    <= audio_d;
    end
  end

  assign tone_io.audio       = audio_q;
  assign tone_io.note_active = (state_q != S_IDLE);
  assign tone_io.level       = level_q;

endmodule
`default_nettype wire

// File: tb/tb_tone_synth.sv
`default_nettype none
// ============================================================================
// tb_tone_synth : randomized + directed bench against a cycle-level behavioural model  (rev 1.0)
// ============================================================================
module tb_tone_synth;
  localparam int CNT_W        = 26;
  localparam int STABLE_CYC   = 4;
  localparam int MIN_HALF     = 16;
  localparam int ENV_W        = 8;
  localparam int ENV_STEP_CYC = 2;
  localparam int LMAX         = (1 << ENV_W) - 1;
  localparam int P_IDLE = 0, P_ATT = 1, P_SUS = 2, P_REL = 3;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  tone_synth_if #(.CNT_W(CNT_W), .ENV_W(ENV_W)) bus ();

  tone_synth #(
    .CNT_W(CNT_W), .STABLE_CYC(STABLE_CYC), .MIN_HALF(MIN_HALF),
    .ENV_W(ENV_W), .ENV_STEP_CYC(ENV_STEP_CYC)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .tone_io(bus)
  );

  always #5 CLK = ~CLK;

  // Model: note word accepted after it has been seen unchanged on STABLE_CYC+1 edges;
  // envelope moves one unit per ENV_STEP_CYC edges; tone period swaps only at toggles.
  int m_cand, m_run, m_acc, m_phase, m_level, m_tick;
  int m_half, m_pos, m_pend, m_pwm, m_cyc, m_last_tog;
  bit m_sq, m_audio;
  int m_iv[$];

  task automatic model_reset();
    m_cand = 0; m_run = 0; m_acc = 0; m_phase = P_IDLE; m_level = 0; m_tick = 0;
    m_half = 0; m_pos = 0; m_pend = 0; m_pwm = 0; m_sq = 0; m_audio = 0;
    m_last_tog = m_cyc;
  endtask

  task automatic go_idle();
    m_phase = P_IDLE; m_sq = 0; m_pos = 0; m_pend = 0; m_tick = 0;
  endtask

  task automatic model_step();
    int eff;
    bit fire;
    bit nxt_audio;
    m_cyc++;
    if (!RST_N) begin
      model_reset();
      return;
    end
    eff  = (bus.mute || int'(bus.half_period) < MIN_HALF) ? 0 : int'(bus.half_period);
    fire = 0;
    if (eff != m_cand) begin
      m_cand = eff;
      m_run  = 0;
    end else if (m_run < STABLE_CYC - 1) begin
      m_run++;
    end else if (m_cand != m_acc) begin
      m_acc = m_cand;
      fire  = 1;
    end
    nxt_audio = m_sq && (m_pwm < m_level);
    m_pwm     = (m_pwm + 1) % (LMAX + 1);
    if (m_phase != P_IDLE) begin
      if (m_pos == m_half - 1) begin
        m_sq  = !m_sq;
        m_pos = 0;
        m_iv.push_back(m_cyc - m_last_tog);
        m_last_tog = m_cyc;
        if (m_pend != 0) begin
          m_half = m_pend;
          m_pend = 0;
        end
      end else begin
        m_pos++;
      end
    end
    if (fire && m_acc != 0) begin
      if (m_phase == P_IDLE) begin
        m_phase = P_ATT; m_half = m_acc; m_pos = 0; m_sq = 0; m_pend = 0; m_tick = 0;
        m_last_tog = m_cyc;
      end else begin
        m_pend = m_acc;
        if (m_phase == P_REL) begin
          m_phase = P_ATT;
          m_tick  = 0;
        end
      end
    end else if (fire) begin
      if (m_phase == P_ATT || m_phase == P_SUS) begin
        m_phase = P_REL;
        m_tick  = 0;
      end
    end else if (m_phase == P_ATT) begin
      if (m_level == LMAX) begin
        m_phase = P_SUS; m_tick = 0;
      end else if (++m_tick == ENV_STEP_CYC) begin
        m_tick = 0;
        m_level++;
        if (m_level == LMAX) m_phase = P_SUS;
      end
    end else if (m_phase == P_REL) begin
      if (m_level == 0) begin
        go_idle();
      end else if (++m_tick == ENV_STEP_CYC) begin
        m_tick = 0;
        m_level--;
        if (m_level == 0) go_idle();
      end
    end
    m_audio = nxt_audio;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  function automatic bit cond(input int what, input int arg);
    case (what)
      0:       return m_phase == arg;
      1:       return (m_phase == P_SUS) && (m_pos == arg);
      2:       return m_iv.size() >= arg;
      3:       return (m_phase == P_REL) && (m_level == arg) && (m_tick == 0);
      default: return m_level == arg;
    endcase
  endfunction

  task automatic wait_for(input int what, input int arg, input int budget, input string name,
                          output int n);
    n = 0;
    while (!cond(what, arg)) begin
      if (n >= budget) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s: timeout after %0d cycles", name, n);
        return;
      end
      cyc();
      n++;
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      chk("cyc_audio", int'(bus.audio), int'(m_audio));
      chk("cyc_active", int'(bus.note_active), int'(m_phase != P_IDLE));
      chk("cyc_level", int'(bus.level), m_level);
    end
  end

  initial begin
    int n;
    int hp, len;
    m_cyc = 0;
    model_reset();
    bus.half_period = '0;
    bus.mute        = 1'b0;
    repeat (3) cyc();
    RST_N = 1'b1;
    chk("reset_active", int'(bus.note_active), 0);
    chk("reset_level", int'(bus.level), 0);
    chk("reset_audio", int'(bus.audio), 0);

    // Note start, attack ramp, sustain
    bus.half_period = 26'd100;
    repeat (4) cyc();
    chk("s1_before_accept", int'(bus.note_active), 0);
    cyc();
    chk("s1_attack_entry", int'(bus.note_active), 1);
    chk("s1_entry_level", int'(bus.level), 0);
    repeat (2) cyc();
    chk("s1_first_step", int'(bus.level), 1);
    repeat (508) cyc();
    chk("s1_level_max", int'(bus.level), 255);
    chk("s1_model_sustain", m_phase, P_SUS);
    chk("s1_half_cycle", (m_iv.size() > 0) ? m_iv[0] : -1, 100);

    // Pitch change mid half-cycle
    wait_for(1, 35, 300, "s3_wait_pos", n);
    m_iv.delete();
    bus.half_period = 26'd60;
    wait_for(2, 4, 600, "s3_wait_toggles", n);
    if (m_iv.size() >= 4) begin
      chk("s3_current_half", m_iv[0], 100);
      chk("s3_new_half_a", m_iv[1], 60);
      chk("s3_new_half_b", m_iv[3], 60);
    end
    chk("s3_level_held", int'(bus.level), 255);

    // Release to idle
    bus.half_period = '0;
    wait_for(0, P_REL, 20, "s4_wait_release", n);
    chk("s4_release_level", int'(bus.level), 255);
    wait_for(0, P_IDLE, 700, "s4_wait_idle", n);
    chk("s4_release_len", n, 510);
    cyc();
    chk("s4_idle_active", int'(bus.note_active), 0);
    chk("s4_idle_audio", int'(bus.audio), 0);

    // Glitching input never accepted
    for (int i = 0; i < 12; i++) begin
      bus.half_period = (i % 2 == 0) ? 26'd100 : 26'd37;
      repeat (2) cyc();
    end
    chk("s2_glitch_idle", int'(bus.note_active), 0);
    bus.half_period = '0;
    repeat (8) cyc();

    // Retrigger from release
    bus.half_period = 26'd150;
    wait_for(0, P_SUS, 700, "s5_wait_sustain", n);
    bus.half_period = '0;
    wait_for(0, P_REL, 20, "s5_wait_release", n);
    wait_for(3, 122, 700, "s5_wait_level", n);
    bus.half_period = 26'd200;
    wait_for(0, P_ATT, 20, "s5_wait_attack", n);
    chk("s5_resume_level", int'(bus.level), 120);
    m_iv.delete();
    wait_for(4, 255, 400, "s5_wait_max", n);
    chk("s5_attack_len", n, 270);
    wait_for(2, 3, 1000, "s5_wait_toggles", n);
    if (m_iv.size() >= 3) begin
      chk("s5_old_half", m_iv[0], 150);
      chk("s5_new_half", m_iv[2], 200);
    end

    // Mute forces release; short words are silence
    bus.mute = 1'b1;
    wait_for(0, P_REL, 20, "s6_wait_mute_release", n);
    wait_for(0, P_IDLE, 700, "s6_wait_mute_idle", n);
    chk("s6_mute_release_len", n, 510);
    bus.half_period = '0;
    bus.mute        = 1'b0;
    repeat (6) cyc();
    bus.half_period = 26'd10;
    repeat (30) cyc();
    chk("s6_short_word_idle", int'(bus.note_active), 0);

    // Asynchronous reset mid-attack
    bus.half_period = 26'd80;
    wait_for(0, P_ATT, 20, "s6_wait_attack", n);
    repeat (100) cyc();
    chk("s6_pre_reset_active", int'(bus.note_active), 1);
    #2 RST_N = 1'b0;
    model_reset();
    #1;
    chk("s6_async_audio", int'(bus.audio), 0);
    chk("s6_async_active", int'(bus.note_active), 0);
    chk("s6_async_level", int'(bus.level), 0);
    repeat (2) cyc();
    RST_N = 1'b1;

    // Randomized words, mutes and hold times
    for (int s = 0; s < 70; s++) begin
      case ($urandom_range(0, 5))
        0:       hp = 0;
        1:       hp = $urandom_range(1, 15);
        5:       hp = int'(bus.half_period);
        default: hp = $urandom_range(16, 60);
      endcase
      bus.half_period = CNT_W'(hp);
      bus.mute        = ($urandom_range(0, 7) == 0);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(20, 400);
      repeat (len) cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
